// File: rtl/contador_mod_updn_if.sv
// Control/status bundle for contador_mod_updn.
// master drives the controls, slave is the counter side.
interface contador_mod_updn_if #(
  parameter int WIDTH = 4
);
  logic             start_i;
  logic             stop_i;
  logic             en_i;
  logic             up_i;
  logic             clr_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] q_o;
  logic             tc_o;
  logic             run_o;

  modport master (
    output start_i, stop_i, en_i, up_i,
    output clr_i, load_i, load_val_i,
    input  q_o, tc_o, run_o
  );

  modport slave (
    input  start_i, stop_i, en_i, up_i,
    input  clr_i, load_i, load_val_i,
    output q_o, tc_o, run_o
  );
endinterface

// File: rtl/contador_mod_updn.sv
// Modulo-N up/down counter with start/stop FSM, load, clear and tc.
// CONTADOR_SAT_EN selects saturating mode with a level tc_o.
module contador_mod_updn #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic              clk,
  input  logic              r,
  contador_mod_updn_if.slave bus
);

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  // Wide limits keep MODULO == 2**WIDTH representable.
  localparam logic [WIDTH:0]   LIM_X = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] LIM_Q = WIDTH'(MODULO - 1);

  logic [0:0]       state;
  logic [0:0]       state_nx;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nx;
  logic             tc_r;
  logic             tc_nx;
  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   ld_x;
  logic             at_top;
  logic             at_bot;
  logic             cnt_en;

  assign q_x    = {1'b0, q_r};
  assign ld_x   = {1'b0, bus.load_val_i};
  assign at_top = (q_x == LIM_X);
  assign at_bot = (q_r == '0);
  assign cnt_en = (state == ST_RUNNING) && bus.en_i;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_STOPPED:
        if (bus.start_i && !bus.stop_i)
          state_nx = ST_RUNNING;
      ST_RUNNING:
        if (bus.stop_i)
          state_nx = ST_STOPPED;
      default:
        state_nx = ST_STOPPED;
    endcase
  end

  always_comb begin
    q_nx  = q_r;
    tc_nx = 1'b0;
    if (bus.clr_i) begin
      q_nx = '0;
    end else if (bus.load_i) begin
      q_nx = (ld_x < MOD_X) ? bus.load_val_i
                            : LIM_Q;
    end else if (cnt_en) begin
`ifdef CONTADOR_SAT_EN
      if (bus.up_i) begin
        if (!at_top)
          q_nx = q_r + WIDTH'(1);
      end else begin
        if (!at_bot)
          q_nx = q_r - WIDTH'(1);
      end
`else
      if (bus.up_i) begin
        if (at_top) begin
          q_nx  = '0;
          tc_nx = 1'b1;
        end else begin
          q_nx = q_r + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          q_nx  = LIM_Q;
          tc_nx = 1'b1;
        end else begin
          q_nx = q_r - WIDTH'(1);
        end
      end
`endif
    end
`ifdef CONTADOR_SAT_EN
    // Level reflects the value being stored, so it rises with q==limit.
    if (!bus.clr_i && !bus.load_i
        && state == ST_RUNNING) begin
      tc_nx = bus.up_i ? ({1'b0, q_nx} == LIM_X)
                       : (q_nx == '0);
    end
`endif
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state <= ST_STOPPED;
      q_r   <= '0;
      tc_r  <= 1'b0;
    end else begin
      state <= state_nx;
      q_r   <= q_nx;
      tc_r  <= tc_nx;
    end
  end

  assign bus.q_o   = q_r;
  assign bus.tc_o  = tc_r;
  assign bus.run_o = (state == ST_RUNNING);

endmodule
